// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator: addressing modes,
// FSM state encoding and per-mode access size / byte-enable pattern.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        NONE = 2'b11
    } addr_mode_e;

    typedef logic [2:0] lsu_state_e;

    localparam lsu_state_e S_IDLE  = 3'd0;
    localparam lsu_state_e S_REQ0  = 3'd1;
    localparam lsu_state_e S_WAIT0 = 3'd2;
    localparam lsu_state_e S_REQ1  = 3'd3;
    localparam lsu_state_e S_WAIT1 = 3'd4;
    localparam lsu_state_e S_DONE  = 3'd5;

    function automatic logic [2:0] size_from_mode(input addr_mode_e mode);
        case (mode)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] be_full(input addr_mode_e mode);
        case (mode)
            BYTE:    return 4'b0001;
            HALF:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Word-wide data-memory bus with req/gnt/rvalid handshake.
interface lsu_mem_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [BE_WIDTH-1:0]   mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Lane alignment: byte enables and shifted store data for both halves of a
// (possibly split) access, plus load-data extraction and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  addr_mode_e  mode,
    input  logic [1:0]  off,
    input  logic        zext,
    input  logic [31:0] wd,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic        split,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rd
);
    logic [3:0]  end_s;
    logic [7:0]  be_wide_s;
    logic [63:0] wdata_wide_s;
    logic [63:0] rdata_shift_s;
    logic        sign_s;

    // The upper half of each widened shift is exactly the second-word lane image.
    always_comb begin
        end_s         = {2'b00, off} + {1'b0, size_from_mode(mode)};
        split         = (end_s > 4'd4);
        be_wide_s     = {4'b0000, be_full(mode)} << off;
        wdata_wide_s  = {32'h0000_0000, wd} << {off, 3'b000};
        rdata_shift_s = {rdata_hi, rdata_lo} >> {off, 3'b000};
        be0           = be_wide_s[3:0];
        be1           = be_wide_s[7:4];
        wdata0        = wdata_wide_s[31:0];
        wdata1        = wdata_wide_s[63:32];
        case (mode)
            BYTE: begin
                sign_s = ~zext & rdata_shift_s[7];
                rd     = {{24{sign_s}}, rdata_shift_s[7:0]};
            end
            HALF: begin
                sign_s = ~zext & rdata_shift_s[15];
                rd     = {{16{sign_s}}, rdata_shift_s[15:0]};
            end
            default: begin
                sign_s = 1'b0;
                rd     = rdata_shift_s[31:0];
            end
        endcase
    end
endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: turns byte/half/word accesses into one or
// two word-aligned req/gnt/rvalid transactions and stalls the core meanwhile.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [2:0]            AddressingControl,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  Stall,
    lsu_mem_initiator_if.master   mem
);
    lsu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, wd_q, wd_d, rdata0_q, rdata0_d, rd_q, rd_d;
    addr_mode_e            mode_q, mode_d;
    logic                  zext_q, zext_d, we_q, we_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;

    logic                  idle_s, split_s;
    addr_mode_e            mode_s;
    logic [1:0]            off_s;
    logic [DATA_WIDTH-1:0] wd_s, rdata_lo_s, rdata_hi_s, wdata0_s, wdata1_s, rd_s;
    logic [BE_WIDTH-1:0]   be0_s, be1_s;

    // In IDLE the aligner sees the live core request so REQ0 can be loaded on entry.
    always_comb begin
        idle_s     = (state_q == S_IDLE);
        mode_s     = idle_s ? addr_mode_e'(AddressingControl[1:0]) : mode_q;
        off_s      = idle_s ? A[1:0] : a_q[1:0];
        wd_s       = idle_s ? WD : wd_q;
        rdata_lo_s = (state_q == S_WAIT1) ? rdata0_q : mem.mem_rdata;
        rdata_hi_s = (state_q == S_WAIT1) ? mem.mem_rdata : {DATA_WIDTH{1'b0}};
        Stall      = (RE | WE) & (state_q != S_DONE);
    end

    lsu_align u_align (
        .mode     (mode_s),
        .off      (off_s),
        .zext     (zext_q),
        .wd       (wd_s),
        .rdata_lo (rdata_lo_s),
        .rdata_hi (rdata_hi_s),
        .split    (split_s),
        .be0      (be0_s),
        .be1      (be1_s),
        .wdata0   (wdata0_s),
        .wdata1   (wdata1_s),
        .rd       (rd_s)
    );

    // Next-state and registered bus outputs; bus fields only change on a transition.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        wd_d        = wd_q;
        mode_d      = mode_q;
        zext_d      = zext_q;
        we_d        = we_q;
        rdata0_d    = rdata0_q;
        rd_d        = rd_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if ((RE | WE) && (mode_s == NONE)) begin
                    state_d = S_DONE;
                    rd_d    = {DATA_WIDTH{1'b0}};
                end else if (RE | WE) begin
                    state_d     = S_REQ0;
                    a_d         = A;
                    wd_d        = WD;
                    mode_d      = mode_s;
                    zext_d      = AddressingControl[2];
                    we_d        = WE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = WE;
                    mem_addr_d  = {A[DATA_WIDTH-1:2], 2'b00};
                    mem_be_d    = be0_s;
                    mem_wdata_d = wdata0_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ0: begin
                if (mem.mem_gnt && we_q && split_s) begin
                    state_d     = S_REQ1;
                    mem_addr_d  = mem_addr_q + 32'd4;
                    mem_be_d    = be1_s;
                    mem_wdata_d = wdata1_s;
                end else if (mem.mem_gnt) begin
                    state_d   = we_q ? S_DONE : S_WAIT0;
                    mem_req_d = 1'b0;
                end else begin
                    state_d = S_REQ0;
                end
            end
            S_WAIT0: begin
                if (mem.mem_rvalid && split_s) begin
                    rdata0_d    = mem.mem_rdata;
                    state_d     = S_REQ1;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = mem_addr_q + 32'd4;
                    mem_be_d    = be1_s;
                    mem_wdata_d = wdata1_s;
                end else if (mem.mem_rvalid) begin
                    rdata0_d = mem.mem_rdata;
                    rd_d     = rd_s;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_WAIT0;
                end
            end
            S_REQ1: begin
                if (mem.mem_gnt) begin
                    state_d   = we_q ? S_DONE : S_WAIT1;
                    mem_req_d = 1'b0;
                end else begin
                    state_d = S_REQ1;
                end
            end
            S_WAIT1: begin
                if (mem.mem_rvalid) begin
                    rd_d    = rd_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= {DATA_WIDTH{1'b0}};
            wd_q        <= {DATA_WIDTH{1'b0}};
            mode_q      <= WORD;
            zext_q      <= 1'b0;
            we_q        <= 1'b0;
            rdata0_q    <= {DATA_WIDTH{1'b0}};
            rd_q        <= {DATA_WIDTH{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {DATA_WIDTH{1'b0}};
            mem_be_q    <= {BE_WIDTH{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            mode_q      <= mode_d;
            zext_q      <= zext_d;
            we_q        <= we_d;
            rdata0_q    <= rdata0_d;
            rd_q        <= rd_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign RD            = rd_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: a byte-level access model predicts the
// bus transactions, Stall timeline and load result for each directed vector.
module tb_lsu_mem_initiator;
    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic        WE;
    logic        RE;
    logic [2:0]  AC;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Stall;

    int          n_cmp;
    int          n_err;
    logic [31:0] last_rd;

    lsu_mem_initiator_if bus ();

    lsu_mem_initiator dut (
        .clk               (clk),
        .rst               (rst),
        .A                 (A),
        .WE                (WE),
        .RE                (RE),
        .AddressingControl (AC),
        .WD                (WD),
        .RD                (RD),
        .Stall             (Stall),
        .mem               (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Byte-by-byte view of an access: each byte lands in the word holding its address.
    task automatic model_txn(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ac,
                             input logic [31:0] r0, input logic [31:0] r1,
                             output int nreq, output logic [31:0] addr0, output logic [31:0] addr1,
                             output logic [3:0] be0, output logic [3:0] be1,
                             output logic [31:0] wd0, output logic [31:0] wd1,
                             output logic [31:0] rd);
        int          size;
        int          lane;
        logic [31:0] ba;
        logic [31:0] val;
        size  = (ac[1:0] == 2'd0) ? 1 : ((ac[1:0] == 2'd1) ? 2 : 4);
        addr0 = a & 32'hFFFF_FFFC;
        addr1 = addr0 + 32'd4;
        be0 = 4'h0; be1 = 4'h0; wd0 = 32'h0; wd1 = 32'h0; val = 32'h0;
        nreq = 1;
        for (int i = 0; i < size; i++) begin
            ba   = a + i;
            lane = int'(ba[1:0]);
            if ((ba & 32'hFFFF_FFFC) == addr0) begin
                be0[lane] = 1'b1;
                wd0[lane*8 +: 8] = wd[i*8 +: 8];
                val[i*8 +: 8] = r0[lane*8 +: 8];
            end else begin
                nreq = 2;
                be1[lane] = 1'b1;
                wd1[lane*8 +: 8] = wd[i*8 +: 8];
                val[i*8 +: 8] = r1[lane*8 +: 8];
            end
        end
        if (size < 4 && !ac[2] && val[size*8-1])
            val = val | ~((32'h1 << (size*8)) - 32'h1);
        rd = val;
        if (ac[1:0] == 2'b11) begin
            nreq = 0;
            rd   = 32'h0;
        end
    endtask

    // Plays the memory and checks every cycle of one access against the model.
    task automatic run_txn(input string nm, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] ac, input logic we, input logic re, input int gd,
                           input logic [31:0] r0, input logic [31:0] r1, input int lit_stall,
                           input logic chk_lit, input logic [31:0] lit_rd);
        int          nreq, n;
        logic [31:0] addr0, addr1, wd0, wd1, rd_m, exp_rd;
        logic [3:0]  be0, be1;
        bit          s_req[32];
        bit          s_gnt[32];
        bit          s_rv[32];
        int          s_idx[32];
        logic [31:0] s_rd[32];
        model_txn(a, wd, ac, r0, r1, nreq, addr0, addr1, be0, be1, wd0, wd1, rd_m);
        n = 1;
        s_req[0] = 1'b0; s_gnt[0] = 1'b0; s_rv[0] = 1'b0; s_idx[0] = 0; s_rd[0] = 32'h0;
        for (int k = 0; k < nreq; k++) begin
            for (int d = 0; d <= gd; d++) begin
                s_req[n] = 1'b1; s_gnt[n] = (d == gd); s_rv[n] = 1'b0; s_idx[n] = k; s_rd[n] = 32'h0;
                n++;
            end
            if (!we) begin
                s_req[n] = 1'b0; s_gnt[n] = 1'b0; s_rv[n] = 1'b1; s_idx[n] = k;
                s_rd[n] = (k == 0) ? r0 : r1;
                n++;
            end
        end
        if (lit_stall >= 0) chk({nm, "_stall_cycles"}, n, lit_stall);
        if (chk_lit) chk({nm, "_model_rd"}, rd_m, lit_rd);
        exp_rd = (ac[1:0] == 2'b11) ? 32'h0 : (we ? last_rd : rd_m);

        @(negedge clk);
        A = a; WD = wd; AC = ac; WE = we; RE = re;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        for (int s = 0; s < n; s++) begin
            if (s > 0) begin
                @(negedge clk);
                bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
            end
            #1;
            chk({nm, "_stall"}, {31'h0, Stall}, 32'h1);
            chk({nm, "_req"}, {31'h0, bus.mem_req}, {31'h0, s_req[s]});
            if (s_req[s]) begin
                chk({nm, "_addr"}, bus.mem_addr, (s_idx[s] == 0) ? addr0 : addr1);
                chk({nm, "_be"}, {28'h0, bus.mem_be}, {28'h0, (s_idx[s] == 0) ? be0 : be1});
                chk({nm, "_we"}, {31'h0, bus.mem_we}, {31'h0, we});
                if (we) chk({nm, "_wdata"}, bus.mem_wdata, (s_idx[s] == 0) ? wd0 : wd1);
            end
            bus.mem_gnt    = s_gnt[s];
            bus.mem_rvalid = s_rv[s];
            bus.mem_rdata  = s_rv[s] ? s_rd[s] : $urandom;
        end
        @(negedge clk);
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        chk({nm, "_done_stall"}, {31'h0, Stall}, 32'h0);
        chk({nm, "_done_req"}, {31'h0, bus.mem_req}, 32'h0);
        chk({nm, "_rd"}, RD, exp_rd);
        WE = 1'b0; RE = 1'b0;
        @(negedge clk);
        #1;
        chk({nm, "_idle_stall"}, {31'h0, Stall}, 32'h0);
        chk({nm, "_rd_hold"}, RD, exp_rd);
        last_rd = exp_rd;
    endtask

    initial begin
        int          nq;
        logic [31:0] m_a0, m_a1, m_w0, m_w1, m_rd;
        logic [3:0]  m_b0, m_b1;
        n_cmp = 0; n_err = 0; last_rd = 32'h0;
        rst = 1'b1; A = 32'h0; WE = 1'b0; RE = 1'b0; AC = 3'b010; WD = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

        // Pin the model against hand-worked cases.
        model_txn(32'h0001_0003, 32'h0, 3'b001, 32'hAB00_0000, 32'h0000_00CD, nq, m_a0, m_a1, m_b0, m_b1, m_w0, m_w1, m_rd);
        chk("model_lh_nreq", nq, 32'd2);
        chk("model_lh_addr1", m_a1, 32'h0001_0004);
        chk("model_lh_be", {24'h0, m_b1, m_b0}, 32'h0000_0018);
        model_txn(32'h0001_0002, 32'h1122_3344, 3'b010, 32'h0, 32'h0, nq, m_a0, m_a1, m_b0, m_b1, m_w0, m_w1, m_rd);
        chk("model_sw_wd0", m_w0, 32'h3344_0000);
        chk("model_sw_wd1", m_w1, 32'h0000_1122);
        chk("model_sw_be", {24'h0, m_b1, m_b0}, 32'h0000_003C);
        model_txn(32'hFFFF_FFFE, 32'h0, 3'b010, 32'h0, 32'h0, nq, m_a0, m_a1, m_b0, m_b1, m_w0, m_w1, m_rd);
        chk("model_wrap_addr1", m_a1, 32'h0000_0000);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_be", {28'h0, bus.mem_be}, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_rd", RD, 32'h0);
        chk("rst_stall", {31'h0, Stall}, 32'h0);
        rst = 1'b0;

        run_txn("sw_aligned", 32'h0001_0000, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 0, 32'h0, 32'h0, 2, 1'b0, 32'h0);
        run_txn("lb_signed", 32'h0001_0003, 32'h0, 3'b000, 1'b0, 1'b1, 0, 32'h80FF_0000, 32'h0, 3, 1'b1, 32'hFFFF_FF80);
        run_txn("lbu", 32'h0001_0003, 32'h0, 3'b100, 1'b0, 1'b1, 0, 32'h80FF_0000, 32'h0, 3, 1'b1, 32'h0000_0080);
        run_txn("lh_split", 32'h0001_0003, 32'h0, 3'b001, 1'b0, 1'b1, 0, 32'hAB00_0000, 32'h0000_00CD, 5, 1'b1, 32'hFFFF_CDAB);
        run_txn("lhu_split", 32'h0001_0003, 32'h0, 3'b101, 1'b0, 1'b1, 0, 32'hAB00_0000, 32'h0000_00CD, 5, 1'b1, 32'h0000_CDAB);
        run_txn("sw_split", 32'h0001_0002, 32'h1122_3344, 3'b010, 1'b1, 1'b0, 0, 32'h0, 32'h0, 3, 1'b0, 32'h0);
        run_txn("lw_gnt_wait", 32'h0002_0000, 32'h0, 3'b010, 1'b0, 1'b1, 3, 32'h1234_5678, 32'h0, 6, 1'b1, 32'h1234_5678);
        run_txn("lw_split", 32'h0002_0001, 32'h0, 3'b110, 1'b0, 1'b1, 0, 32'h4433_2211, 32'h8877_6655, 5, 1'b1, 32'h5544_3322);
        run_txn("sb", 32'h0003_0001, 32'h0000_00A5, 3'b000, 1'b1, 1'b0, 0, 32'h0, 32'h0, 2, 1'b0, 32'h0);
        run_txn("sh_split_wait", 32'h0003_0003, 32'h0000_BEEF, 3'b001, 1'b1, 1'b0, 2, 32'h0, 32'h0, 7, 1'b0, 32'h0);
        run_txn("re_we_both", 32'h0003_0004, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b1, 0, 32'h0, 32'h0, 2, 1'b0, 32'h0);
        run_txn("lw_wrap", 32'hFFFF_FFFE, 32'h0, 3'b010, 1'b0, 1'b1, 1, 32'hBBAA_0000, 32'h0000_DDCC, 7, 1'b1, 32'hDDCC_BBAA);
        run_txn("lh_pos", 32'h0004_0002, 32'h0, 3'b001, 1'b0, 1'b1, 0, 32'h7FFF_0000, 32'h0, 3, 1'b1, 32'h0000_7FFF);
        run_txn("mode_none", 32'h0005_0000, 32'h0, 3'b011, 1'b0, 1'b1, 0, 32'h0, 32'h0, 1, 1'b1, 32'h0);
        run_txn("lb_after_none", 32'h0005_0000, 32'h0, 3'b000, 1'b0, 1'b1, 0, 32'h0000_00F0, 32'h0, 3, 1'b1, 32'hFFFF_FFF0);

        // Reset while waiting for read data, then a stray rvalid.
        @(negedge clk);
        A = 32'h0006_0004; AC = 3'b010; RE = 1'b1; WE = 1'b0;
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #1;
        chk("wait0_addr_live", bus.mem_addr, 32'h0006_0004);
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'h0, bus.mem_req}, 32'h0);
        chk("midrst_addr", bus.mem_addr, 32'h0);
        chk("midrst_rd", RD, 32'h0);
        @(negedge clk);
        rst = 1'b0; RE = 1'b0;
        @(negedge clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        chk("stray_rv_rd", RD, 32'h0);
        chk("stray_rv_req", {31'h0, bus.mem_req}, 32'h0);
        chk("stray_rv_stall", {31'h0, Stall}, 32'h0);
        last_rd = 32'h0;
        run_txn("after_rst_lhu", 32'h0007_0000, 32'h0, 3'b101, 1'b0, 1'b1, 0, 32'h0000_9876, 32'h0, 3, 1'b1, 32'h0000_9876);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
